qpu_op_engine: RTL

QPU_OP_ENGINE -- requirements
Module: qpu_op_engine

---
 rtl/qpu_op_engine.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/qpu_op_engine.sv
// Basis-state operation engine: validates an op in LOAD, runs it for 1..15 EXEC cycles,
// reports through DONE/ERR and then waits for the host to drop qop_start.
module qpu_op_engine (
  input  logic         clk,
  input  logic         rst,
  input  logic         qop_start,
  input  logic [3:0]   qop_code,
  input  logic [127:0] qop_param_flat,
  input  logic [3:0]   qubit_count,
  input  logic [15:0]  quantum_state,
  output logic         qop_done,
  output logic         qop_error,
  output logic [127:0] qop_result_flat,
  output logic [15:0]  quantum_result,
  output logic         quantum_valid
);
  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_X    = 4'd1;
  localparam logic [3:0] OP_CNOT = 4'd2;
  localparam logic [3:0] OP_SWAP = 4'd3;
  localparam logic [3:0] OP_MEAS = 4'd4;
  localparam logic [3:0] OP_ROTL = 4'd5;

  typedef enum logic [2:0] {IDLE, LOAD, EXEC, DONE, ERR, WAIT_LOW} state_t;
  state_t state, state_nxt;

  logic [3:0]  code_q, qc_q;
  logic [7:0]  p0_q, p1_q, cnt_q;
  logic [15:0] s_q;
  logic [4:0]  pop_q;

  // Only the first two parameter bytes carry meaning for the current op set.
  logic [7:0]  p0_in, p1_in;
  logic [15:0] mask_in;
  logic        chk_fail;
  logic        unused_params;
  assign p0_in         = qop_param_flat[7:0];
  assign p1_in         = qop_param_flat[15:8];
  assign unused_params = ^qop_param_flat[127:16];
  assign mask_in       = (16'h1 << qubit_count) - 16'h1;

  always_comb begin
    chk_fail = 1'b0;
    if (qubit_count == 4'd0 || qop_code > OP_ROTL)
      chk_fail = 1'b1;
    else if (qop_code == OP_CNOT)
      chk_fail = (p0_in[3:0] >= qubit_count) || (p1_in[3:0] >= qubit_count) ||
                 (p0_in[3:0] == p1_in[3:0]);
    else if (qop_code == OP_SWAP)
      chk_fail = (p0_in[3:0] >= qubit_count) || (p1_in[3:0] >= qubit_count);
  end

  // One EXEC step of the latched op; exec_last marks the final cycle.
  logic [3:0]  idx_a, idx_b;
  logic [15:0] mask_q, s_nxt;
  logic [4:0]  pop_nxt;
  logic        exec_last;
  assign idx_a  = p0_q[3:0];
  assign idx_b  = p1_q[3:0];
  assign mask_q = (16'h1 << qc_q) - 16'h1;

  always_comb begin
    s_nxt     = s_q;
    pop_nxt   = pop_q;
    exec_last = 1'b1;
    case (code_q)
      OP_X:    s_nxt = s_q ^ ({p1_q, p0_q} & mask_q);
      OP_CNOT: if (s_q[idx_a]) s_nxt[idx_b] = ~s_q[idx_b];
      OP_SWAP: begin
        s_nxt[idx_a] = s_q[idx_b];
        s_nxt[idx_b] = s_q[idx_a];
      end
      OP_MEAS: begin
        pop_nxt   = pop_q + {4'd0, s_q[cnt_q[3:0]]};
        exec_last = (cnt_q + 8'd1 == {4'd0, qc_q});
      end
      OP_ROTL: begin
        // Zero amount still spends one cycle but leaves the state alone.
        if (idx_a != 4'd0)
          s_nxt = ((s_q << 1) | (s_q >> (qc_q - 4'd1))) & mask_q;
        exec_last = (cnt_q + 8'd1 >= {4'd0, idx_a});
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (qop_start) state_nxt = LOAD;
      LOAD:     state_nxt = chk_fail ? ERR : EXEC;
      EXEC:     if (exec_last) state_nxt = DONE;
      DONE:     state_nxt = WAIT_LOW;
      ERR:      state_nxt = WAIT_LOW;
      WAIT_LOW: if (!qop_start) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      code_q          <= '0;
      qc_q            <= '0;
      p0_q            <= '0;
      p1_q            <= '0;
      cnt_q           <= '0;
      s_q             <= '0;
      pop_q           <= '0;
      qop_done        <= 1'b0;
      qop_error       <= 1'b0;
      quantum_valid   <= 1'b0;
      qop_result_flat <= '0;
      quantum_result  <= '0;
    end else begin
      case (state)
        LOAD: begin
          code_q <= qop_code;
          qc_q   <= qubit_count;
          p0_q   <= p0_in;
          p1_q   <= p1_in;
          s_q    <= quantum_state & mask_in;
          cnt_q  <= '0;
          pop_q  <= '0;
        end
        EXEC: begin
          s_q   <= s_nxt;
          pop_q <= pop_nxt;
          cnt_q <= cnt_q + 8'd1;
        end
        DONE: begin
          qop_done        <= 1'b1;
          qop_error       <= 1'b0;
          quantum_valid   <= 1'b1;
          qop_result_flat <= {88'd0, 3'd0, pop_q, 4'd0, code_q, cnt_q, s_q};
          quantum_result  <= s_q;
        end
        ERR: begin
          qop_done        <= 1'b1;
          qop_error       <= 1'b1;
          quantum_valid   <= 1'b0;
          qop_result_flat <= {96'd0, 4'd0, code_q, 24'd0};
          quantum_result  <= '0;
        end
        WAIT_LOW: begin
          qop_error <= 1'b0;
          if (!qop_start) begin
            qop_done      <= 1'b0;
            quantum_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
